// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot loader and the 9-bit accumulator core.
// Contents:
//   LDR_PC_WIDTH / LDR_INSTR_WIDTH / LDR_CYC_WIDTH - default widths shared with the core
//   ldr_state_e    - loader FSM state encoding
//   hi_byte_legal  - framing check on the high byte of a machine-code word
package prog_loader_pkg;

    localparam int LDR_PC_WIDTH    = 12;
    localparam int LDR_INSTR_WIDTH = 9;
    localparam int LDR_CYC_WIDTH   = 16;

    typedef enum logic [2:0] {
        LD_LO   = 3'd0,
        LD_HI   = 3'd1,
        WRITE   = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4,
        HALT    = 3'd5,
        ERR     = 3'd6
    } ldr_state_e;

    // Only bit 0 of the high byte carries instruction data; anything above it is a framing error.
    function automatic logic hi_byte_legal(input logic [7:0] hi_byte);
        return (hi_byte[7:1] == 7'd0);
    endfunction

endpackage

// File: rtl/prog_loader_sat_counter.sv
// Saturating up-counter used to measure core run time.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset, clears count
//   i_clr    - synchronous clear (priority over i_en)
//   i_en     - count enable; count holds at all-ones once reached
//   o_count  - registered count value
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count register: clear wins, then increment unless already saturated.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_clr) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/prog_loader.sv
// Boot loader for the 9-bit accumulator core. Packs a byte stream (low byte, then high byte) into
// machine-code words, writes them to instruction memory, releases the core and pulses start, then
// times the run until the core reports done and freezes it again.
// Ports:
//   clk, reset          - clock; asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last - byte stream in (s_last only legal on a high byte)
//   im_we/im_addr/im_data - instruction memory write port, one strobe per word
//   core_reset, start   - core control: active-high reset, one-cycle start pulse
//   done                - core completion level
//   busy, load_err      - status: busy outside HALT/ERR, sticky load error
//   word_count          - words written so far
//   run_cycles          - cycles from start pulse to done (saturating)
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int PC_WIDTH    = LDR_PC_WIDTH,
    parameter int INSTR_WIDTH = LDR_INSTR_WIDTH,
    parameter int MAX_WORDS   = 1 << PC_WIDTH,
    parameter int CYC_WIDTH   = LDR_CYC_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [7:0]             s_data,
    input  logic                   s_last,
    output logic                   im_we,
    output logic [PC_WIDTH-1:0]    im_addr,
    output logic [INSTR_WIDTH-1:0] im_data,
    output logic                   core_reset,
    output logic                   start,
    input  logic                   done,
    output logic                   busy,
    output logic                   load_err,
    output logic [PC_WIDTH:0]      word_count,
    output logic [CYC_WIDTH-1:0]   run_cycles
);

    localparam logic [PC_WIDTH:0] C_MAX_WORDS = (PC_WIDTH+1)'(MAX_WORDS);

    ldr_state_e               r_state;
    ldr_state_e               w_next_state;
    logic                     w_accept;
    logic [7:0]               r_lo_byte;
    logic                     r_last;
    logic [PC_WIDTH:0]        r_word_count;

    logic                     r_s_ready;
    logic                     r_im_we;
    logic [PC_WIDTH-1:0]      r_im_addr;
    logic [INSTR_WIDTH-1:0]   r_im_data;
    logic                     r_core_reset;
    logic                     r_start;
    logic                     r_busy;
    logic                     r_load_err;

    logic                     w_s_ready;
    logic                     w_im_we;
    logic                     w_core_reset;
    logic                     w_start;
    logic                     w_busy;
    logic                     w_load_err;

    // s_ready is a flop, so acceptance never depends combinationally on s_valid.
    assign w_accept = s_valid && r_s_ready;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= LD_LO;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LD_LO: begin
                if (w_accept) begin
                    w_next_state = s_last ? ERR : LD_HI;
                end else begin
                    w_next_state = LD_LO;
                end
            end
            LD_HI: begin
                if (w_accept) begin
                    if (!hi_byte_legal(s_data) || (r_word_count == C_MAX_WORDS)) begin
                        w_next_state = ERR;
                    end else begin
                        w_next_state = WRITE;
                    end
                end else begin
                    w_next_state = LD_HI;
                end
            end
            WRITE:   w_next_state = r_last ? RELEASE : LD_LO;
            RELEASE: w_next_state = RUN;     // done is deliberately ignored here: stale from a prior run
            RUN: begin
                if (done) begin
                    w_next_state = HALT;
                end else begin
                    w_next_state = RUN;
                end
            end
            HALT:    w_next_state = HALT;
            ERR:     w_next_state = ERR;
            default: w_next_state = ERR;
        endcase
    end

    // Output decode from the next state; the values are registered below so each output
    // is valid during the state it belongs to.
    always_comb begin
        w_s_ready    = 1'b0;
        w_im_we      = 1'b0;
        w_core_reset = 1'b1;
        w_start      = 1'b0;
        w_busy       = 1'b1;
        w_load_err   = 1'b0;
        case (w_next_state)
            LD_LO:   w_s_ready = 1'b1;
            LD_HI:   w_s_ready = 1'b1;
            WRITE:   w_im_we   = 1'b1;
            RELEASE: begin
                w_core_reset = 1'b0;
                w_start      = 1'b1;
            end
            RUN:     w_core_reset = 1'b0;
            HALT:    w_busy = 1'b0;
            ERR: begin
                w_busy     = 1'b0;
                w_load_err = 1'b1;
            end
            default: begin
                w_busy     = 1'b0;
                w_load_err = 1'b1;
            end
        endcase
    end

    // Control output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s_ready    <= 1'b1;
            r_im_we      <= 1'b0;
            r_core_reset <= 1'b1;
            r_start      <= 1'b0;
            r_busy       <= 1'b1;
            r_load_err   <= 1'b0;
        end else begin
            r_s_ready    <= w_s_ready;
            r_im_we      <= w_im_we;
            r_core_reset <= w_core_reset;
            r_start      <= w_start;
            r_busy       <= w_busy;
            r_load_err   <= w_load_err;
        end
    end

    // Word assembly and memory write port; address/data are held between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lo_byte    <= 8'd0;
            r_last       <= 1'b0;
            r_im_addr    <= {PC_WIDTH{1'b0}};
            r_im_data    <= {INSTR_WIDTH{1'b0}};
            r_word_count <= {(PC_WIDTH+1){1'b0}};
        end else begin
            if (w_accept && (r_state == LD_LO)) begin
                r_lo_byte <= s_data;
            end
            if ((r_state == LD_HI) && (w_next_state == WRITE)) begin
                r_last    <= s_last;
                r_im_addr <= r_word_count[PC_WIDTH-1:0];
                r_im_data <= INSTR_WIDTH'({s_data[0], r_lo_byte});
            end
            // Overflow is caught in LD_HI, so the count never exceeds MAX_WORDS.
            if (r_state == WRITE) begin
                r_word_count <= r_word_count + {{PC_WIDTH{1'b0}}, 1'b1};
            end
        end
    end

    // Run timer: cleared on the start cycle, counts RUN cycles that do not see done.
    sat_counter #(
        .WIDTH (CYC_WIDTH)
    ) u_run_cnt (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (r_state == RELEASE),
        .i_en    ((r_state == RUN) && !done),
        .o_count (run_cycles)
    );

    assign s_ready    = r_s_ready;
    assign im_we      = r_im_we;
    assign im_addr    = r_im_addr;
    assign im_data    = r_im_data;
    assign core_reset = r_core_reset;
    assign start      = r_start;
    assign busy       = r_busy;
    assign load_err   = r_load_err;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a default-parameter instance (A) and a small instance (B,
// MAX_WORDS=4, CYC_WIDTH=4) share the stream inputs.
module tb_prog_loader;

    logic        clk;
    logic        reset;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        done;

    logic        a_s_ready, a_im_we, a_core_reset, a_start, a_busy, a_load_err;
    logic [11:0] a_im_addr;
    logic [8:0]  a_im_data;
    logic [12:0] a_word_count;
    logic [15:0] a_run_cycles;

    logic        b_s_ready, b_im_we, b_core_reset, b_start, b_busy, b_load_err;
    logic [11:0] b_im_addr;
    logic [8:0]  b_im_data;
    logic [12:0] b_word_count;
    logic [3:0]  b_run_cycles;

    int n_checks = 0;
    int n_errors = 0;
    int a_start_cnt = 0;
    int a_we_cnt = 0;
    int b_we_cnt = 0;

    prog_loader u_a (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
        .s_last(s_last), .im_we(a_im_we), .im_addr(a_im_addr), .im_data(a_im_data),
        .core_reset(a_core_reset), .start(a_start), .done(done), .busy(a_busy),
        .load_err(a_load_err), .word_count(a_word_count), .run_cycles(a_run_cycles)
    );

    prog_loader #(.PC_WIDTH(12), .INSTR_WIDTH(9), .MAX_WORDS(4), .CYC_WIDTH(4)) u_b (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
        .s_last(s_last), .im_we(b_im_we), .im_addr(b_im_addr), .im_data(b_im_data),
        .core_reset(b_core_reset), .start(b_start), .done(done), .busy(b_busy),
        .load_err(b_load_err), .word_count(b_word_count), .run_cycles(b_run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        dn;
        logic        rdy;
        logic        we;
        logic [11:0] addr;
        logic [8:0]  data;
        logic        cr;
        logic        st;
        logic        bsy;
        logic        err;
        logic [12:0] wc;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance past the rising edge, then tally pulses.
    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic dn);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        done    = dn;
        @(posedge clk);
        #1;
        if (a_start) a_start_cnt++;
        if (a_im_we) a_we_cnt++;
        if (b_im_we) b_we_cnt++;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, ".s_ready"},    a_s_ready,    1);
        chk({tag, ".im_we"},      a_im_we,      0);
        chk({tag, ".im_addr"},    a_im_addr,    0);
        chk({tag, ".im_data"},    a_im_data,    0);
        chk({tag, ".core_reset"}, a_core_reset, 1);
        chk({tag, ".start"},      a_start,      0);
        chk({tag, ".busy"},       a_busy,       1);
        chk({tag, ".load_err"},   a_load_err,   0);
        chk({tag, ".word_count"}, a_word_count, 0);
        chk({tag, ".run_cycles"}, a_run_cycles, 0);
    endtask

    task automatic do_reset(input string tag);
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; done = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_a(tag);
        reset = 1'b1;
        a_start_cnt = 0;
        a_we_cnt = 0;
        b_we_cnt = 0;
    endtask

    initial begin
        //               v  d      l  dn   rdy we addr    data     cr st bsy err wc
        tbl[0] = '{1'b1, 8'h3A, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 13'd0};
        tbl[1] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 9'h13A, 1'b1, 1'b0, 1'b1, 1'b0, 13'd0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 9'h13A, 1'b1, 1'b0, 1'b1, 1'b0, 13'd1};
        tbl[3] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 9'h13A, 1'b1, 1'b0, 1'b1, 1'b0, 13'd1};
        tbl[4] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 12'h001, 9'h010, 1'b1, 1'b0, 1'b1, 1'b0, 13'd1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h001, 9'h010, 1'b0, 1'b1, 1'b1, 1'b0, 13'd2};
        // done high during the start cycle must be ignored; stray byte must not be taken
        tbl[6] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 12'h001, 9'h010, 1'b0, 1'b0, 1'b1, 1'b0, 13'd2};

        reset = 1'b0;
        do_reset("rst0");

        // Load two words, release the core.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].dn);
            chk($sformatf("v%0d.s_ready", i),    a_s_ready,    tbl[i].rdy);
            chk($sformatf("v%0d.im_we", i),      a_im_we,      tbl[i].we);
            chk($sformatf("v%0d.im_addr", i),    a_im_addr,    tbl[i].addr);
            chk($sformatf("v%0d.im_data", i),    a_im_data,    tbl[i].data);
            chk($sformatf("v%0d.core_reset", i), a_core_reset, tbl[i].cr);
            chk($sformatf("v%0d.start", i),      a_start,      tbl[i].st);
            chk($sformatf("v%0d.busy", i),       a_busy,       tbl[i].bsy);
            chk($sformatf("v%0d.load_err", i),   a_load_err,   tbl[i].err);
            chk($sformatf("v%0d.word_count", i), a_word_count, tbl[i].wc);
        end
        chk("run.entry_cycles", a_run_cycles, 0);

        // Run 25 cycles without done, then done.
        for (int i = 0; i < 25; i++) step(1'b1, 8'h44, 1'b0, 1'b0);
        chk("run.s_ready_low", a_s_ready, 0);
        chk("run.word_count_frozen", a_word_count, 2);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("halt.run_cycles", a_run_cycles, 25);
        chk("halt.core_reset", a_core_reset, 1);
        chk("halt.busy", a_busy, 0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b1);
        chk("halt.held_cycles", a_run_cycles, 25);
        chk("halt.held_busy", a_busy, 0);
        chk("halt.s_ready", a_s_ready, 0);
        chk("load.start_pulses", a_start_cnt, 1);
        chk("load.we_pulses", a_we_cnt, 2);

        // s_last on a low byte.
        do_reset("rst1");
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("lolast.load_err", a_load_err, 1);
        chk("lolast.busy", a_busy, 0);
        chk("lolast.s_ready", a_s_ready, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0, 1'b0);
        chk("lolast.err_sticky", a_load_err, 1);
        chk("lolast.core_reset", a_core_reset, 1);
        chk("lolast.no_we", a_we_cnt, 0);
        chk("lolast.no_start", a_start_cnt, 0);

        // Illegal high byte.
        do_reset("rst2");
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        chk("hibad.load_err", a_load_err, 1);
        chk("hibad.im_we", a_im_we, 0);
        chk("hibad.word_count", a_word_count, 0);

        // Memory overflow on instance B (4 words max).
        do_reset("rst3");
        for (int w = 0; w < 4; w++) begin
            step(1'b1, 8'(w + 1), 1'b0, 1'b0);
            step(1'b1, 8'h00, 1'b0, 1'b0);
            chk($sformatf("ovf.w%0d.im_we", w), b_im_we, 1);
            chk($sformatf("ovf.w%0d.im_addr", w), b_im_addr, w);
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        chk("ovf.full_count", b_word_count, 4);
        chk("ovf.no_err_yet", b_load_err, 0);
        step(1'b1, 8'h20, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        chk("ovf.load_err", b_load_err, 1);
        chk("ovf.im_we", b_im_we, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf.we_pulses", b_we_cnt, 4);
        chk("ovf.count_held", b_word_count, 4);

        // Run-cycle saturation on instance B (4-bit counter).
        do_reset("rst4");
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("sat.start", b_start, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("sat.saturated", b_run_cycles, 15);
        chk("sat.still_busy", b_busy, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("sat.halt_busy", b_busy, 0);
        chk("sat.halt_cycles", b_run_cycles, 15);
        chk("sat.core_reset", b_core_reset, 1);

        // Asynchronous reset during the second word's write, then reload.
        do_reset("rst5");
        step(1'b1, 8'h3A, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h10, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        chk("midrst.in_write", a_im_we, 1);
        chk("midrst.addr1", a_im_addr, 1);
        reset = 1'b0;
        #1;
        chk_reset_a("midrst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b1, 1'b0);
        chk("reload.im_we", a_im_we, 1);
        chk("reload.im_addr", a_im_addr, 0);
        chk("reload.im_data", a_im_data, 9'h1AA);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("reload.start", a_start, 1);
        chk("reload.word_count", a_word_count, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
